// File: rtl/dll_delay_ctrl.sv
// Digital DLL delay-code controller: filters phase-detector decisions into a
// saturating 6-bit delay code, gates it to the delay cell and flags lock.
module dll_delay_ctrl #(
    parameter int unsigned INIT_CODE      = 32,
    parameter int unsigned FILTER_DEPTH   = 4,
    parameter int unsigned LOCK_TOGGLES   = 3,
    parameter int unsigned STARTUP_CYCLES = 16
) (
    input  logic CLKI,
    input  logic RSTN,
    input  logic PHASE_LATE,
    input  logic FREEZE,
    input  logic UPDATE_N,
    output logic DCNTL0,
    output logic DCNTL1,
    output logic DCNTL2,
    output logic DCNTL3,
    output logic DCNTL4,
    output logic DCNTL5,
    output logic LOCK,
    output logic SAT
);

    localparam logic [5:0] INIT_C         = 6'(INIT_CODE);
    localparam logic [3:0] FILT_DEPTH_C   = 4'(FILTER_DEPTH);
    localparam logic [2:0] LOCK_C         = 3'(LOCK_TOGGLES);
    localparam logic [7:0] STARTUP_LAST_C = 8'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t     state_r;
    logic       ps_meta_r;
    logic       ps_r;
    logic [7:0] startup_cnt_r;
    logic [3:0] filt_cnt_r;
    logic       filt_dir_r;
    logic [2:0] rev_cnt_r;
    logic       last_valid_r;
    logic       last_up_r;
    logic [5:0] code_r;
    logic [5:0] dcntl_r;
    logic       lock_r;
    logic       sat_r;

    logic [3:0] filt_cnt_inc_s;
    logic       filt_active_s;
    logic       step_s;
    logic       step_up_s;
    logic       at_bound_s;
    logic       real_step_s;
    logic       sat_step_s;
    logic       reversal_s;
    logic       same_dir_s;
    logic [2:0] rev_next_s;
    logic [5:0] code_next_s;

    // Filter decision and step classification for the current cycle
    always_comb begin
        filt_cnt_inc_s = 4'd1;
        rev_next_s     = 3'd0;
        code_next_s    = code_r;
        if (ps_r == filt_dir_r) begin
            filt_cnt_inc_s = filt_cnt_r + 4'd1;
        end else begin
            filt_cnt_inc_s = 4'd1;
        end
        filt_active_s = (state_r != ST_STARTUP) && !FREEZE;
        step_s        = filt_active_s && (filt_cnt_inc_s == FILT_DEPTH_C);
        step_up_s     = !ps_r;
        at_bound_s    = step_up_s ? (code_r == 6'd63) : (code_r == 6'd0);
        real_step_s   = step_s && !at_bound_s;
        sat_step_s    = step_s && at_bound_s;
        reversal_s    = real_step_s && last_valid_r && (last_up_r != step_up_s);
        same_dir_s    = real_step_s && last_valid_r && (last_up_r == step_up_s);
        // Reversal count holds at its lock threshold while dithering in LOCKED
        if (reversal_s) begin
            if (rev_cnt_r == LOCK_C) begin
                rev_next_s = rev_cnt_r;
            end else begin
                rev_next_s = rev_cnt_r + 3'd1;
            end
        end else begin
            rev_next_s = 3'd0;
        end
        if (real_step_s) begin
            if (step_up_s) begin
                code_next_s = code_r + 6'd1;
            end else begin
                code_next_s = code_r - 6'd1;
            end
        end else begin
            code_next_s = code_r;
        end
    end

    // Two-flop synchronizer for the asynchronous phase-detector result
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            ps_meta_r <= 1'b0;
            ps_r      <= 1'b0;
        end else begin
            ps_meta_r <= PHASE_LATE;
            ps_r      <= ps_meta_r;
        end
    end

    // Loop state machine: startup, filter, code, reversal tracking and outputs
    always_ff @(posedge CLKI or negedge RSTN) begin
        if (!RSTN) begin
            state_r       <= ST_STARTUP;
            startup_cnt_r <= 8'd0;
            filt_cnt_r    <= 4'd0;
            filt_dir_r    <= 1'b0;
            rev_cnt_r     <= 3'd0;
            last_valid_r  <= 1'b0;
            last_up_r     <= 1'b0;
            code_r        <= INIT_C;
            dcntl_r       <= INIT_C;
            lock_r        <= 1'b0;
            sat_r         <= 1'b0;
        end else begin
            if (!UPDATE_N) begin
                dcntl_r <= code_r;
            end
            case (state_r)
                ST_STARTUP: begin
                    if (startup_cnt_r == STARTUP_LAST_C) begin
                        state_r <= ST_ACQUIRE;
                    end else begin
                        startup_cnt_r <= startup_cnt_r + 8'd1;
                    end
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    if (filt_active_s) begin
                        filt_dir_r <= ps_r;
                        filt_cnt_r <= step_s ? 4'd0 : filt_cnt_inc_s;
                        if (real_step_s) begin
                            code_r       <= code_next_s;
                            sat_r        <= 1'b0;
                            last_valid_r <= 1'b1;
                            last_up_r    <= step_up_s;
                        end
                        if (sat_step_s) begin
                            sat_r <= 1'b1;
                        end
                        if (step_s) begin
                            if ((state_r == ST_LOCKED) && (same_dir_s || sat_step_s)) begin
                                state_r   <= ST_ACQUIRE;
                                lock_r    <= 1'b0;
                                rev_cnt_r <= 3'd0;
                            end else if ((state_r == ST_ACQUIRE) && (rev_next_s == LOCK_C)) begin
                                state_r   <= ST_LOCKED;
                                lock_r    <= 1'b1;
                                rev_cnt_r <= rev_next_s;
                            end else begin
                                rev_cnt_r <= rev_next_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_STARTUP;
                    lock_r  <= 1'b0;
                end
            endcase
        end
    end

    assign DCNTL0 = dcntl_r[0];
    assign DCNTL1 = dcntl_r[1];
    assign DCNTL2 = dcntl_r[2];
    assign DCNTL3 = dcntl_r[3];
    assign DCNTL4 = dcntl_r[4];
    assign DCNTL5 = dcntl_r[5];
    assign LOCK   = lock_r;
    assign SAT    = sat_r;

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Directed bench for dll_delay_ctrl: reset, ramp/saturation, lock acquire and
// loss, update gating and freeze, with hand-computed expectations.
module tb_dll_delay_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       phase_late = 1'b1;
    logic       freeze = 1'b0;
    logic       update_n = 1'b0;
    wire  [5:0] dcntl;
    wire        lock;
    wire        sat;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    dll_delay_ctrl dut (
        .CLKI      (clk),
        .RSTN      (rstn),
        .PHASE_LATE(phase_late),
        .FREEZE    (freeze),
        .UPDATE_N  (update_n),
        .DCNTL0    (dcntl[0]),
        .DCNTL1    (dcntl[1]),
        .DCNTL2    (dcntl[2]),
        .DCNTL3    (dcntl[3]),
        .DCNTL4    (dcntl[4]),
        .DCNTL5    (dcntl[5]),
        .LOCK      (lock),
        .SAT       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the n-th rising edge since reset release
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Asynchronous reset with an immediate check before any clock edge
    task automatic apply_reset(input string tag);
        rstn = 1'b0;
        #2;
        check({tag, "_dcntl"}, {2'b00, dcntl}, 8'd32);
        check({tag, "_lock"}, {7'd0, lock}, 8'd0);
        check({tag, "_sat"}, {7'd0, sat}, 8'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1;
        // Ramp down with PHASE_LATE=1: first step at edge 20, DCNTL one edge later
        apply_reset("por");
        go(16);  check("startup_hold", {2'b00, dcntl}, 8'd32);
        go(20);  check("first_step_latency", {2'b00, dcntl}, 8'd32);
        go(21);  check("ramp_31", {2'b00, dcntl}, 8'd31);
        go(25);  check("ramp_30", {2'b00, dcntl}, 8'd30);
        go(77);  check("ramp_17", {2'b00, dcntl}, 8'd17);
        apply_reset("midrun_rst");
        go(20);  check("rst_startup_again", {2'b00, dcntl}, 8'd32);
        go(21);  check("rst_ramp_31", {2'b00, dcntl}, 8'd31);
        go(144); check("ramp_1", {2'b00, dcntl}, 8'd1);
        go(145); check("ramp_0", {2'b00, dcntl}, 8'd0);
                 check("ramp_0_sat", {7'd0, sat}, 8'd0);
        go(147); check("pre_sat", {7'd0, sat}, 8'd0);
        go(148); check("sat_low", {7'd0, sat}, 8'd1);
        go(160); check("sat_hold_code", {2'b00, dcntl}, 8'd0);
                 check("sat_hold_sat", {7'd0, sat}, 8'd1);
                 check("sat_no_lock", {7'd0, lock}, 8'd0);

        // Dither 32/31 in 4-cycle blocks; lock on the third reversal
        apply_reset("lock_rst");
        go(18);  phase_late = 1'b0;
        go(22);  phase_late = 1'b1;
        go(26);  phase_late = 1'b0;
        go(30);  phase_late = 1'b1;
        go(31);  check("pre_lock", {7'd0, lock}, 8'd0);
                 check("dither_31", {2'b00, dcntl}, 8'd31);
        go(32);  check("lock_set", {7'd0, lock}, 8'd1);
        go(33);  check("dither_32", {2'b00, dcntl}, 8'd32);
        go(34);  phase_late = 1'b0;
        go(36);  check("lock_hold_a", {7'd0, lock}, 8'd1);
        go(37);  check("dither_31b", {2'b00, dcntl}, 8'd31);
        go(41);  check("dither_32b", {2'b00, dcntl}, 8'd32);
                 check("lock_hold_b", {7'd0, lock}, 8'd1);
        go(43);  check("lock_hold_c", {7'd0, lock}, 8'd1);
        go(44);  check("lock_lost", {7'd0, lock}, 8'd0);
        go(45);  check("rise_33", {2'b00, dcntl}, 8'd33);
        go(165); check("rise_63", {2'b00, dcntl}, 8'd63);
        go(167); check("pre_sat_high", {7'd0, sat}, 8'd0);
        go(168); check("sat_high", {7'd0, sat}, 8'd1);
                 check("sat_high_lock", {7'd0, lock}, 8'd0);

        // Update gating, then a 20-cycle freeze in the middle of a filter window
        phase_late = 1'b1;
        update_n = 1'b1;
        apply_reset("gate_rst");
        go(34);  check("gate_hold", {2'b00, dcntl}, 8'd32);
        update_n = 1'b0;
        go(35);  check("gate_release", {2'b00, dcntl}, 8'd28);
        go(42);  check("pre_freeze", {2'b00, dcntl}, 8'd26);
        freeze = 1'b1;
        go(50);  check("freeze_mid", {2'b00, dcntl}, 8'd26);
        go(62);  check("freeze_end", {2'b00, dcntl}, 8'd26);
                 check("freeze_lock", {7'd0, lock}, 8'd0);
        freeze = 1'b0;
        go(64);  check("resume_wait", {2'b00, dcntl}, 8'd26);
        go(65);  check("resume_step", {2'b00, dcntl}, 8'd25);
        go(68);  check("no_dup_step", {2'b00, dcntl}, 8'd25);
        go(69);  check("next_step", {2'b00, dcntl}, 8'd24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
